// File: rtl/fft_bfly_scheduler.sv
// -----------------------------------------------------------------------------
// fft_bfly_scheduler
//
// Sequencer for an in-place radix-2 decimation-in-time FFT that time-shares a
// single butterfly datapath. It walks LOG2N stages of N/2 butterflies each.
// For every butterfly it issues the two data-RAM read addresses and the
// twiddle-ROM index. PIPE_LAT cycles later it issues the matching write-back
// addresses. The block does no data reordering. Input samples are expected in
// bit-reversed order, and results come out in natural order.
//
// Parameters
//   LOG2N     log2 of the FFT size (N = 2**LOG2N, N/2 butterflies per stage)
//   PIPE_LAT  read-issue to write-back latency of the butterfly, 1..15
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   start     begin a transform (ignored unless idle)
//   stall     hold issue while in the issue phase
//             (present only when FFT_SCHED_STALL_EN is defined)
//   busy      high from the first issue cycle through the last write-back cycle
//   done      one-cycle pulse in the cycle after the final write-back
//   stage     current stage number 0..LOG2N-1
//   rd_en     read issue strobe
//   rd_addr0  upper-leg read address (din0)
//   rd_addr1  lower-leg read address (din1)
//   tw_idx    twiddle index k of W_N^k
//   wr_en     write-back strobe
//   wr_addr0  write address for dout0
//   wr_addr1  write address for dout1
//
// Build option
//   FFT_SCHED_STALL_EN  adds the stall input. In the default build the port
//                       does not exist, and issue is never interrupted.
//
// The last write of stage s lands in the final drain cycle, one edge before
// the first read of stage s+1. The data RAM must therefore give
// write-then-read ordering across that edge.
// -----------------------------------------------------------------------------
module fft_bfly_scheduler #(
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 2,
  localparam int SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1,
  localparam int BW      = LOG2N - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef FFT_SCHED_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [BW-1:0]    tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BW-1:0] B_LAST   = '1;
  localparam logic [SW-1:0] STG_LAST = SW'(LOG2N - 1);
  localparam logic [3:0]    D_LAST   = 4'(PIPE_LAT - 1);

  // Mask selecting the position-within-group bits of a butterfly index.
  function automatic logic [LOG2N-1:0] pos_mask(input logic [SW-1:0] s);
    return (LOG2N'(1) << s) - LOG2N'(1);
  endfunction

  // Upper-leg address: open a zero at bit s between the group and the
  // position fields. This equals grp*2*half + pos.
  function automatic logic [LOG2N-1:0] addr0_f(input logic [SW-1:0] s,
                                               input logic [BW-1:0] b);
    logic [LOG2N-1:0] bw;
    logic [LOG2N-1:0] m;
    bw = {1'b0, b};
    m  = pos_mask(s);
    return ((bw & ~m) << 1) | (bw & m);
  endfunction

  // Bit s of the upper-leg address is always clear, so OR acts as + half.
  function automatic logic [LOG2N-1:0] addr1_f(input logic [SW-1:0] s,
                                               input logic [BW-1:0] b);
    return addr0_f(s, b) | (LOG2N'(1) << s);
  endfunction

  function automatic logic [BW-1:0] tw_f(input logic [SW-1:0] s,
                                         input logic [BW-1:0] b);
    logic [LOG2N-1:0] m;
    logic [BW-1:0]    pos;
    logic [SW-1:0]    sh;
    m   = pos_mask(s);
    pos = b & m[BW-1:0];
    sh  = STG_LAST - s;
    return pos << sh;
  endfunction

  logic [1:0]    state;
  logic [BW-1:0] b_q;
  logic [SW-1:0] stage_q;
  logic [3:0]    dcnt_q;
  logic          iss_vld_p0;

  logic [1:0]    nxt_state;
  logic [BW-1:0] nxt_b;
  logic [SW-1:0] nxt_stage;
  logic [3:0]    nxt_dcnt;

  logic [PIPE_LAT-1:0]            wr_vld_p;
  logic [PIPE_LAT-1:0][LOG2N-1:0] wr_a0_p;
  logic [PIPE_LAT-1:0][LOG2N-1:0] wr_a1_p;

  // In the stall build, a stalled cycle presents the held butterfly but does
  // not issue it. The FSM advances only on an actual issue.
`ifdef FFT_SCHED_STALL_EN
  assign rd_en = iss_vld_p0 & ~stall;
`else
  assign rd_en = iss_vld_p0;
`endif

  assign stage = stage_q;

  always_comb begin
    nxt_state = state;
    nxt_b     = b_q;
    nxt_stage = stage_q;
    nxt_dcnt  = dcnt_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_ISSUE;
          nxt_b     = '0;
          nxt_stage = '0;
        end
      end
      S_ISSUE: begin
        if (rd_en) begin
          if (b_q == B_LAST) begin
            nxt_state = S_DRAIN;
            nxt_dcnt  = '0;
          end else begin
            nxt_b = b_q + BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (stage_q == STG_LAST) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_ISSUE;
            nxt_stage = stage_q + SW'(1);
            nxt_b     = '0;
          end
        end else begin
          nxt_dcnt = dcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_stage = '0;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // ---- p0: FSM, read issue and registered status outputs ----
  // Outputs are registered from the next-state values, so they line up with
  // the state they describe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      b_q        <= '0;
      stage_q    <= '0;
      dcnt_q     <= '0;
      iss_vld_p0 <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_addr0   <= '0;
      rd_addr1   <= '0;
      tw_idx     <= '0;
    end else begin
      state      <= nxt_state;
      b_q        <= nxt_b;
      stage_q    <= nxt_stage;
      dcnt_q     <= nxt_dcnt;
      iss_vld_p0 <= (nxt_state == S_ISSUE);
      busy       <= (nxt_state == S_ISSUE) || (nxt_state == S_DRAIN);
      done       <= (nxt_state == S_DONE);
      if (nxt_state == S_ISSUE) begin
        rd_addr0 <= addr0_f(nxt_stage, nxt_b);
        rd_addr1 <= addr1_f(nxt_stage, nxt_b);
        tw_idx   <= tw_f(nxt_stage, nxt_b);
      end
    end
  end

  // ---- p1..pPIPE_LAT: write-back delay line ----
  // This line never stalls. Each address slot loads only when a valid entry
  // moves into it, so wr_addr holds its last value between writes.
  // A reset drops every write that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p <= '0;
      wr_a0_p  <= '0;
      wr_a1_p  <= '0;
    end else begin
      wr_vld_p[0] <= rd_en;
      if (rd_en) begin
        wr_a0_p[0] <= rd_addr0;
        wr_a1_p[0] <= rd_addr1;
      end
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_vld_p[i] <= wr_vld_p[i-1];
        if (wr_vld_p[i-1]) begin
          wr_a0_p[i] <= wr_a0_p[i-1];
          wr_a1_p[i] <= wr_a1_p[i-1];
        end
      end
    end
  end

  assign wr_en    = wr_vld_p[PIPE_LAT-1];
  assign wr_addr0 = wr_a0_p[PIPE_LAT-1];
  assign wr_addr1 = wr_a1_p[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_scheduler
//
// Testbench for fft_bfly_scheduler. It drives three instances (PIPE_LAT = 2,
// 1 and 4) from the same stimulus. Each instance is compared against a
// schedule model built from the transform rules: per-stage butterfly order,
// address formulas and write-back latency. When FFT_SCHED_STALL_EN is
// defined, the stall input is exercised as well.
//
// Cycle k is the period after clock edge k. Inputs for cycle k are driven
// just after that edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fft_bfly_scheduler;

  localparam int LOG2N = 5;
  localparam int NB    = 16;
  localparam int NS    = 5;
  localparam int NI    = 3;
  localparam int MAXC  = 160;

  logic clk = 1'b0;
  logic rst;
  logic start;
`ifdef FFT_SCHED_STALL_EN
  logic stall;
`endif

  always #5 clk = ~clk;

  logic [NI-1:0]        busy_o, done_o, rd_o, wr_o;
  logic [NI-1:0][2:0]   stg_o;
  logic [NI-1:0][4:0]   a0_o, a1_o, wa0_o, wa1_o;
  logic [NI-1:0][3:0]   tw_o;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fft_bfly_scheduler #(
      .LOG2N   (LOG2N),
      .PIPE_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
`ifdef FFT_SCHED_STALL_EN
      .stall   (stall),
`endif
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .stage   (stg_o[g]),
      .rd_en   (rd_o[g]),
      .rd_addr0(a0_o[g]),
      .rd_addr1(a1_o[g]),
      .tw_idx  (tw_o[g]),
      .wr_en   (wr_o[g]),
      .wr_addr0(wa0_o[g]),
      .wr_addr1(wa1_o[g])
    );
  end

  function automatic int pl_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus tables, indexed by cycle within one transform run
  bit start_v [MAXC];
  bit stall_v [MAXC];

  // Expected schedule per instance
  bit e_rd   [NI][MAXC];
  bit e_wr   [NI][MAXC];
  bit e_busy [NI][MAXC];
  bit e_done [NI][MAXC];
  int e_a0   [NI][MAXC];
  int e_a1   [NI][MAXC];
  int e_tw   [NI][MAXC];
  int e_stg  [NI][MAXC];
  int e_wa0  [NI][MAXC];
  int e_wa1  [NI][MAXC];
  int e_done_c [NI];

  // Observations used for the sweep and hazard checks
  int cov      [NI][NS][32];
  int first_rd [NI][NS];
  int last_wr  [NI][NS];
  int n_rd     [NI];
  int n_wr     [NI];
  int obs_done [NI];

  int base_done [NI] = '{91, 86, 101};
  int sp_c  [5] = '{1, 16, 19, 20, 88};
  int sp_a0 [5] = '{0, 30, 0, 1, 15};
  int sp_a1 [5] = '{1, 31, 2, 3, 31};
  int sp_tw [5] = '{0, 0, 0, 8, 15};

  // Schedule model: butterflies issue back-to-back from cycle 1, skipping
  // stalled cycles. Each stage is followed by PIPE_LAT drain cycles, and
  // each write lands PIPE_LAT cycles after its read. A reset in cycle rc
  // blanks every cycle after it.
  task automatic build_model(input int g, input int rc);
    int pl, c, half, grp, pos, a0;
    pl = pl_of(g);
    for (int k = 0; k < MAXC; k++) begin
      e_rd[g][k] = 0; e_wr[g][k] = 0; e_busy[g][k] = 0; e_done[g][k] = 0;
      e_a0[g][k] = 0; e_a1[g][k] = 0; e_tw[g][k] = 0; e_stg[g][k] = 0;
      e_wa0[g][k] = 0; e_wa1[g][k] = 0;
    end
    c = 1;
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < NB; b++) begin
        while (stall_v[c] && c < MAXC - 30) c++;
        half = 1 << s;
        grp  = b >> s;
        pos  = b & (half - 1);
        a0   = grp * 2 * half + pos;
        e_rd[g][c]  = 1;
        e_a0[g][c]  = a0;
        e_a1[g][c]  = a0 + half;
        e_tw[g][c]  = pos << (LOG2N - 1 - s);
        e_stg[g][c] = s;
        e_wr[g][c + pl]  = 1;
        e_wa0[g][c + pl] = a0;
        e_wa1[g][c + pl] = a0 + half;
        c++;
      end
      c += pl;
    end
    for (int k = 1; k < c; k++) e_busy[g][k] = 1;
    e_done[g][c] = 1;
    e_done_c[g]  = c;
    if (rc >= 0) begin
      for (int k = rc + 1; k < MAXC; k++) begin
        e_rd[g][k] = 0; e_wr[g][k] = 0; e_busy[g][k] = 0; e_done[g][k] = 0;
      end
    end
  endtask

  task automatic check_cycle(input int k, input int rc, input bit spot);
    for (int g = 0; g < NI; g++) begin
      string p;
      p = $sformatf("pl%0d c%0d", pl_of(g), k);
      chk({p, " rd_en"}, rd_o[g], e_rd[g][k]);
      chk({p, " wr_en"}, wr_o[g], e_wr[g][k]);
      chk({p, " busy"},  busy_o[g], e_busy[g][k]);
      chk({p, " done"},  done_o[g], e_done[g][k]);
      if (e_rd[g][k]) begin
        chk({p, " rd_addr0"}, a0_o[g], e_a0[g][k]);
        chk({p, " rd_addr1"}, a1_o[g], e_a1[g][k]);
        chk({p, " tw_idx"},   tw_o[g], e_tw[g][k]);
        chk({p, " stage"},    stg_o[g], e_stg[g][k]);
      end
      if (e_wr[g][k]) begin
        chk({p, " wr_addr0"}, wa0_o[g], e_wa0[g][k]);
        chk({p, " wr_addr1"}, wa1_o[g], e_wa1[g][k]);
      end
      if (rc >= 0 && k > rc) begin
        chk({p, " rst stage"},    stg_o[g], 0);
        chk({p, " rst rd_addr0"}, a0_o[g], 0);
        chk({p, " rst wr_addr0"}, wa0_o[g], 0);
      end
      if (spot && g == 0) begin
        for (int i = 0; i < 5; i++) begin
          if (k == sp_c[i]) begin
            chk({p, " spot a0"}, a0_o[g], sp_a0[i]);
            chk({p, " spot a1"}, a1_o[g], sp_a1[i]);
            chk({p, " spot tw"}, tw_o[g], sp_tw[i]);
          end
        end
      end
      if (rd_o[g] === 1'b1) begin
        if (stg_o[g] < NS) begin
          cov[g][stg_o[g]][a0_o[g]]++;
          cov[g][stg_o[g]][a1_o[g]]++;
        end
        if (n_rd[g] / NB < NS && n_rd[g] % NB == 0) first_rd[g][n_rd[g] / NB] = k;
        n_rd[g]++;
      end
      if (wr_o[g] === 1'b1) begin
        if (n_wr[g] / NB < NS && n_wr[g] % NB == NB - 1) last_wr[g][n_wr[g] / NB] = k;
        n_wr[g]++;
      end
      if (done_o[g] === 1'b1) obs_done[g] = k;
    end
  endtask

  // One transform run. rc >= 0 asserts rst during cycle rc.
  task automatic run_tx(input int rc, input bit spot, input bit chk_done, input int done_add);
    int last;
    for (int g = 0; g < NI; g++) begin
      build_model(g, rc);
      n_rd[g] = 0; n_wr[g] = 0; obs_done[g] = -1;
      for (int s = 0; s < NS; s++) begin
        first_rd[g][s] = -1; last_wr[g][s] = -1;
        for (int a = 0; a < 32; a++) cov[g][s][a] = 0;
      end
    end
    last = (rc >= 0) ? rc + 8 : e_done_c[NI-1];
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      start = start_v[k];
      rst   = (k == rc);
`ifdef FFT_SCHED_STALL_EN
      stall = stall_v[k];
`endif
      @(negedge clk);
      check_cycle(k, rc, spot);
    end
    start = 1'b0;
    rst   = 1'b0;
`ifdef FFT_SCHED_STALL_EN
    stall = 1'b0;
`endif
    if (rc < 0) begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("pl%0d read count", pl_of(g)), n_rd[g], NS * NB);
        chk($sformatf("pl%0d write count", pl_of(g)), n_wr[g], NS * NB);
        for (int s = 0; s < NS; s++)
          for (int a = 0; a < 32; a++)
            chk($sformatf("pl%0d sweep s%0d a%0d", pl_of(g), s, a), cov[g][s][a], 1);
        for (int s = 0; s < NS - 1; s++)
          chk($sformatf("pl%0d hazard s%0d wr%0d rd%0d", pl_of(g), s, last_wr[g][s], first_rd[g][s+1]),
              (last_wr[g][s] >= 0 && last_wr[g][s] < first_rd[g][s+1]) ? 1 : 0, 1);
        if (chk_done)
          chk($sformatf("pl%0d done cycle", pl_of(g)), obs_done[g], base_done[g] + done_add);
      end
    end
    for (int k = 0; k < MAXC; k++) begin
      start_v[k] = 0;
      stall_v[k] = 0;
    end
  endtask

  initial begin
    int rc, nx;
    rst   = 1'b1;
    start = 1'b0;
`ifdef FFT_SCHED_STALL_EN
    stall = 1'b0;
`endif
    for (int k = 0; k < MAXC; k++) begin
      start_v[k] = 0;
      stall_v[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset busy", busy_o[g], 0);
      chk("reset done", done_o[g], 0);
      chk("reset rd_en", rd_o[g], 0);
      chk("reset wr_en", wr_o[g], 0);
      chk("reset stage", stg_o[g], 0);
      chk("reset rd_addr0", a0_o[g], 0);
      chk("reset rd_addr1", a1_o[g], 0);
      chk("reset tw_idx", tw_o[g], 0);
      chk("reset wr_addr0", wa0_o[g], 0);
      chk("reset wr_addr1", wa1_o[g], 0);
    end

    // Plain transform with spot values
    start_v[0] = 1;
    run_tx(-1, 1, 1, 0);

    // Start re-asserted while busy
    start_v[0] = 1; start_v[5] = 1; start_v[50] = 1;
    run_tx(-1, 1, 1, 0);

    // Abort by reset, then a clean transform
    start_v[0] = 1;
    run_tx(40, 0, 0, 0);
    start_v[0] = 1;
    run_tx(-1, 1, 1, 0);

`ifdef FFT_SCHED_STALL_EN
    start_v[0] = 1; stall_v[3] = 1; stall_v[4] = 1; stall_v[5] = 1;
    run_tx(-1, 0, 1, 3);
`endif

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 80)) : -1;
      start_v[0] = 1;
      nx = $urandom_range(0, 3);
      for (int i = 0; i < nx; i++)
        start_v[$urandom_range(1, (rc >= 0) ? rc - 1 : 80)] = 1;
`ifdef FFT_SCHED_STALL_EN
      for (int k = 1; k <= 70; k++) stall_v[k] = ($urandom_range(0, 7) == 0);
`endif
      run_tx(rc, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
